// File: rtl/car_park_pkg.sv
// Shared types and sizing helpers for the car park gate controller.
package car_park_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    WAIT_PW  = 3'd1,
    WRONG_PW = 3'd2,
    GRANTED  = 3'd3,
    STOP     = 3'd4,
    LOCKED   = 3'd5
  } gate_state_e;

  // Width needed to count wrong entries 0..max_tries.
  function automatic int tc_width(input int max_tries);
    return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
  endfunction

  // Width of the shared timeout/lockout timer.
  function automatic int tmr_width(input int timeout_cycles, input int lock_cycles);
    int m;
    m = (timeout_cycles > lock_cycles) ? timeout_cycles : lock_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/park_down_timer.sv
// Loadable down-counter shared by the password timeout and lockout paths.
// zero means the count is already 0 or becomes 0 on the next enabled
// decrement, so the caller can leave a state on exactly the Nth cycle.
module park_down_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; decrement saturates at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt <= W'(1));

endmodule

// File: rtl/car_park_gate_ctrl.sv
// Password-protected single-lane car park gate controller.
// Optional feature: define PARK_COUNT_EN to add an occupancy counter, the
// exit_pulse input and a live park_full flag.
module car_park_gate_ctrl
  import car_park_pkg::*;
#(
  parameter int                   PW_WIDTH       = 4,
  parameter logic [PW_WIDTH-1:0]  PASSWORD       = 4'b0001,
  parameter int                   MAX_TRIES      = 3,
  parameter int                   TIMEOUT_CYCLES = 16,
  parameter int                   LOCK_CYCLES    = 8,
  parameter int                   CAPACITY       = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            front_sensor,
  input  logic                            back_sensor,
  input  logic                            pw_valid,
  input  logic [PW_WIDTH-1:0]             pw_in,
`ifdef PARK_COUNT_EN
  input  logic                            exit_pulse,
`endif
  output logic                            gate_open,
  output logic                            green_led,
  output logic                            red_led,
  output logic                            locked,
  output logic [tc_width(MAX_TRIES)-1:0]  try_cnt,
  output logic                            park_full
);

  localparam int TCW = tc_width(MAX_TRIES);
  localparam int TW  = tmr_width(TIMEOUT_CYCLES, LOCK_CYCLES);

  gate_state_e    state, state_n;
  logic [TCW-1:0] try_n;
  logic           tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0]  tmr_val;
  logic           pw_ok;
  logic           car_in;
  logic           full;

  assign pw_ok = (pw_in == PASSWORD);

  park_down_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // State and wrong-entry counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      try_cnt <= '0;
    end else begin
      state   <= state_n;
      try_cnt <= try_n;
    end
  end

  // Next-state, timer control and try counter update.
  always_comb begin
    state_n  = state;
    try_n    = try_cnt;
    tmr_load = 1'b0;
    tmr_val  = TW'(TIMEOUT_CYCLES);
    tmr_en   = 1'b0;
    car_in   = 1'b0;
    case (state)
      IDLE: begin
        // pw_valid is deliberately not looked at here.
        if (front_sensor && !full) begin
          state_n  = WAIT_PW;
          try_n    = '0;
          tmr_load = 1'b1;
        end
      end
      WAIT_PW, WRONG_PW: begin
        // Priority: strobe, then car gone, then timeout.
        if (pw_valid) begin
          if (pw_ok) begin
            state_n = GRANTED;
          end else if (try_cnt >= TCW'(MAX_TRIES - 1)) begin
            state_n  = LOCKED;
            try_n    = TCW'(MAX_TRIES);
            tmr_load = 1'b1;
            tmr_val  = TW'(LOCK_CYCLES);
          end else begin
            state_n  = WRONG_PW;
            try_n    = try_cnt + 1'b1;
            tmr_load = 1'b1;
          end
        end else if (!front_sensor) begin
          state_n = IDLE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_zero) state_n = IDLE;
        end
      end
      GRANTED: begin
        if (back_sensor) begin
          if (front_sensor) begin
            state_n = STOP;
          end else begin
            state_n = IDLE;
            car_in  = 1'b1;
          end
        end
      end
      STOP: begin
        // A wrong entry here is not counted against the driver.
        if (pw_valid) begin
          if (pw_ok) state_n = GRANTED;
        end else if (!front_sensor && !back_sensor) begin
          state_n = IDLE;
        end
      end
      LOCKED: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_n = IDLE;
          try_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs registered from the current state, so they lag it by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_open <= 1'b0;
      green_led <= 1'b0;
      red_led   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      gate_open <= 1'b0;
      green_led <= 1'b0;
      red_led   <= 1'b0;
      locked    <= 1'b0;
      case (state)
        WRONG_PW: red_led <= 1'b1;
        GRANTED: begin
          gate_open <= 1'b1;
          green_led <= 1'b1;
        end
        STOP:     red_led <= 1'b1;
        LOCKED: begin
          red_led <= 1'b1;
          locked  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PARK_COUNT_EN
  localparam int CW = (CAPACITY < 1) ? 1 : $clog2(CAPACITY + 1);

  logic [CW-1:0] occ, occ_n;

  // Occupancy: entry on GRANTED->IDLE, exit on exit_pulse, both cancel out.
  always_comb begin
    occ_n = occ;
    if (car_in && !exit_pulse && occ != CW'(CAPACITY))
      occ_n = occ + 1'b1;
    else if (!car_in && exit_pulse && occ != '0)
      occ_n = occ - 1'b1;
  end

  // Count and full flag update together so park_full always matches occ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= '0;
      park_full <= 1'b0;
    end else begin
      occ       <= occ_n;
      park_full <= (occ_n == CW'(CAPACITY));
    end
  end

  assign full = park_full;
`else
  logic unused_ok;

  assign full      = 1'b0;
  assign park_full = 1'b0;
  assign unused_ok = car_in & (CAPACITY > 0);
`endif

endmodule
